// File: rtl/pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp
//
// Purpose:
//   Soft-start / slew-limited duty source for a PWM generator. A target duty
//   is accepted over a valid/ready handshake. The duty output then walks
//   toward that target by at most STEP counts every HOLD_PERIODS PWM periods.
//   The duty output only ever changes on a PWM period boundary, so the
//   downstream generator never sees a mid-period update. A private phase
//   counter mirrors the generator's 0..PERIOD counter, and the boundary is
//   also exported as a strobe.
//
// Parameters:
//   DUTY_W        width of the duty / target buses (unsigned)
//   PERIOD        generator counter terminal value (period = PERIOD+1 clocks)
//   STEP          largest duty change per step (>= 1)
//   HOLD_PERIODS  PWM periods between successive steps (>= 1)
//   DUTY_MAX      clamp applied to an accepted target
//
// Ports:
//   clk_i           clock, rising edge
//   rst_ni          asynchronous, active-low reset
//   tgt_duty_i      requested duty
//   tgt_valid_i     tgt_duty_i is valid
//   tgt_ready_o     block can accept a target (idle)
//   duty_o          registered duty to the PWM generator
//   period_start_o  one-clock strobe during the first clock of a period
//   busy_o          ramp in progress
//   done_o          one-clock strobe: duty has reached the accepted target
// -----------------------------------------------------------------------------
module pwm_duty_ramp #(
    parameter int unsigned DUTY_W       = 32,
    parameter int unsigned PERIOD       = 100,
    parameter int unsigned STEP         = 1,
    parameter int unsigned HOLD_PERIODS = 1,
    parameter int unsigned DUTY_MAX     = 101
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DUTY_W-1:0] tgt_duty_i,
    input  logic              tgt_valid_i,
    output logic              tgt_ready_o,
    output logic [DUTY_W-1:0] duty_o,
    output logic              period_start_o,
    output logic              busy_o,
    output logic              done_o
);

    // Phase counter covers 0..PERIOD inclusive.
    localparam int PH_W = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);
    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(PERIOD);

    // Hold counter covers 0..HOLD_PERIODS-1; sized so HOLD_PERIODS==1 still
    // yields a one-bit counter.
    localparam int HC_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_PERIODS - 1);

    localparam logic [DUTY_W-1:0] DUTY_CLAMP = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] STEP_AMT   = DUTY_W'(STEP);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_e;

    state_e            state_q;
    logic [PH_W-1:0]   phase_q;
    logic [HC_W-1:0]   hold_cnt_q;
    logic [DUTY_W-1:0] duty_q;
    logic [DUTY_W-1:0] tgt_q;
    logic              period_start_q;
    logic              busy_q;
    logic              done_q;

    logic              bnd;
    logic [PH_W-1:0]   phase_d;
    logic [DUTY_W-1:0] tgt_clamped;
    logic [DUTY_W-1:0] gap_up;
    logic [DUTY_W-1:0] gap_dn;
    logic [DUTY_W-1:0] duty_d;
    logic              accept;

    // Boundary edge: the clock edge on which the phase wraps back to 0.
    assign bnd     = (phase_q == PHASE_LAST);
    assign phase_d = bnd ? '0 : phase_q + 1'b1;

    assign tgt_clamped = (tgt_duty_i > DUTY_CLAMP) ? DUTY_CLAMP : tgt_duty_i;
    assign accept      = tgt_valid_i && (state_q == ST_IDLE);

    // Next duty for a step. Each step is limited to the remaining distance,
    // so the subtraction in the selected direction never wraps and the duty
    // never overshoots the target.
    always_comb begin
        gap_up = tgt_q - duty_q;
        gap_dn = duty_q - tgt_q;
        duty_d = duty_q;
        if (duty_q < tgt_q) begin
            duty_d = duty_q + ((gap_up < STEP_AMT) ? gap_up : STEP_AMT);
        end else if (duty_q > tgt_q) begin
            duty_d = duty_q - ((gap_dn < STEP_AMT) ? gap_dn : STEP_AMT);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            phase_q        <= '0;
            hold_cnt_q     <= '0;
            duty_q         <= '0;
            tgt_q          <= '0;
            period_start_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            // The phase counter free-runs in every state. The strobe is
            // registered from the boundary, so it is high exactly while
            // phase==0; the phase==0 right after reset has no preceding
            // boundary and therefore no strobe.
            phase_q        <= phase_d;
            period_start_q <= bnd;
            done_q         <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        tgt_q      <= tgt_clamped;
                        hold_cnt_q <= '0;
                        if (tgt_clamped == duty_q) begin
                            // Already there: report completion, no ramp.
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RAMP;
                            busy_q  <= 1'b1;
                        end
                    end
                end

                ST_RAMP: begin
                    if (bnd) begin
                        if (hold_cnt_q == HOLD_LAST) begin
                            hold_cnt_q <= '0;
                            duty_q     <= duty_d;
                            if (duty_d == tgt_q) begin
                                // Landing step: done, busy falling and
                                // ready rising all share this edge.
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Ready is a pure decode of the state register; it never looks at
    // tgt_valid_i.
    assign tgt_ready_o    = (state_q == ST_IDLE);
    assign duty_o         = duty_q;
    assign period_start_o = period_start_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ramp
//
// Self-checking bench for pwm_duty_ramp. Two instances share clock and reset:
// u_dut (HOLD_PERIODS=1) and u_dut3 (HOLD_PERIODS=3), both PERIOD=100,
// STEP=10, DUTY_MAX=101. Expected duty sequences are generated by a small
// model when a target is driven, queued, and popped as duty changes appear.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ramp;

    localparam int W      = 32;
    localparam int PER    = 100;
    localparam int PLEN   = PER + 1;
    localparam int STEPV  = 10;
    localparam int DMAX   = 101;

    logic          clk;
    logic          rst_n;

    logic [W-1:0]  tgt1;
    logic          valid1;
    logic          ready1;
    logic [W-1:0]  duty1;
    logic          ps1;
    logic          busy1;
    logic          done1;

    logic [W-1:0]  tgt3;
    logic          valid3;
    logic          ready3;
    logic [W-1:0]  duty3;
    logic          ps3;
    logic          busy3;
    logic          done3;

    int            checks_total;
    int            checks_passed;
    logic [W-1:0]  md [2];          // model duty per instance (0: hold1, 1: hold3)
    logic [W-1:0]  exp_q [$];       // expected duty steps
    int            pulse_q [$];     // expected period_start cycle indices

    pwm_duty_ramp #(
        .DUTY_W(W), .PERIOD(PER), .STEP(STEPV), .HOLD_PERIODS(1), .DUTY_MAX(DMAX)
    ) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .tgt_duty_i(tgt1), .tgt_valid_i(valid1),
        .tgt_ready_o(ready1), .duty_o(duty1), .period_start_o(ps1),
        .busy_o(busy1), .done_o(done1)
    );

    pwm_duty_ramp #(
        .DUTY_W(W), .PERIOD(PER), .STEP(STEPV), .HOLD_PERIODS(3), .DUTY_MAX(DMAX)
    ) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .tgt_duty_i(tgt3), .tgt_valid_i(valid3),
        .tgt_ready_o(ready3), .duty_o(duty3), .period_start_o(ps3),
        .busy_o(busy3), .done_o(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------------
    task automatic test_reset();
        int k;
        rst_n  = 1'b0;
        valid1 = 1'b0; tgt1 = '0;
        valid3 = 1'b0; tgt3 = '0;
        repeat (3) @(negedge clk);
        checks_total++;
        if (duty1 !== 0 || ready1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 || ps1 !== 1'b0)
            $display("FAIL reset_state: duty=%0d ready=%b busy=%b done=%b ps=%b, want 0/1/0/0/0",
                     duty1, ready1, busy1, done1, ps1);
        else checks_passed++;
        checks_total++;
        if (duty3 !== 0 || ready3 !== 1'b1 || busy3 !== 1'b0)
            $display("FAIL reset_state_h3: duty=%0d ready=%b busy=%b, want 0/1/0", duty3, ready3, busy3);
        else checks_passed++;

        pulse_q.delete();
        pulse_q.push_back(PLEN);
        pulse_q.push_back(2 * PLEN);
        pulse_q.push_back(3 * PLEN);
        rst_n = 1'b1;
        for (k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (ps1 === 1'b1) begin
                checks_total++;
                if (pulse_q.size() == 0) begin
                    $display("FAIL period_start_extra: pulse at clk %0d, want none", k);
                end else if (pulse_q[0] != k) begin
                    $display("FAIL period_start_time: pulse at clk %0d, want clk %0d", k, pulse_q[0]);
                    void'(pulse_q.pop_front());
                end else begin
                    checks_passed++;
                    void'(pulse_q.pop_front());
                end
            end
        end
        checks_total++;
        if (pulse_q.size() != 0)
            $display("FAIL period_start_missing: %0d pulses not seen, want 0", pulse_q.size());
        else checks_passed++;
        checks_total++;
        if (duty1 !== 0 || ready1 !== 1'b1 || busy1 !== 1'b0)
            $display("FAIL idle_state: duty=%0d ready=%b busy=%b, want 0/1/0", duty1, ready1, busy1);
        else checks_passed++;
        md[0] = '0;
        md[1] = '0;
        $display("reset: idle 400 clk done, 3 period_start pulses expected");
    endtask

    // ---------------------------------------------------------------------
    // One transaction: accept req on instance sel, follow the ramp to done.
    // Must be entered at a negedge; returns at a negedge.
    task automatic run_ramp(input bit sel, input logic [W-1:0] req, input int hold, input bit inject);
        logic [W-1:0] t, cur, prev, d, want;
        logic         ps, bz, dn, rdy;
        int           nsteps, budget, iter, ps_cnt, last_change;
        bit           seen_done;

        exp_q.delete();
        t   = (req > DMAX) ? W'(DMAX) : req;
        cur = md[sel];
        while (cur != t) begin
            if (cur < t) cur = ((t - cur) > STEPV) ? cur + STEPV : t;
            else         cur = ((cur - t) > STEPV) ? cur - STEPV : t;
            exp_q.push_back(cur);
        end
        nsteps = exp_q.size();

        rdy = sel ? ready3 : ready1;
        checks_total++;
        if (rdy !== 1'b1) $display("FAIL ready_before_accept: ready=%b, want 1", rdy);
        else checks_passed++;

        if (sel) begin tgt3 = req; valid3 = 1'b1; end
        else     begin tgt1 = req; valid1 = 1'b1; end

        budget      = (nsteps + 2) * PLEN * hold + 20;
        prev        = md[sel];
        seen_done   = 0;
        ps_cnt      = 0;
        last_change = -1;
        for (iter = 0; iter < budget && !seen_done; iter++) begin
            @(negedge clk);
            d   = sel ? duty3  : duty1;
            ps  = sel ? ps3    : ps1;
            bz  = sel ? busy3  : busy1;
            dn  = sel ? done3  : done1;
            rdy = sel ? ready3 : ready1;

            if (iter == 0) begin
                if (sel) valid3 = 1'b0; else valid1 = 1'b0;
                checks_total++;
                if (nsteps > 0 && (bz !== 1'b1 || rdy !== 1'b0 || dn !== 1'b0))
                    $display("FAIL accept_ramp: busy=%b ready=%b done=%b, want 1/0/0", bz, rdy, dn);
                else if (nsteps == 0 && (bz !== 1'b0 || dn !== 1'b1 || d !== prev))
                    $display("FAIL accept_equal: busy=%b done=%b duty=%0d, want 0/1/%0d", bz, dn, d, prev);
                else checks_passed++;
            end

            if (inject && (iter == 40 || iter == 140)) begin
                checks_total++;
                if (rdy !== 1'b0) $display("FAIL ready_while_busy: ready=%b, want 0", rdy);
                else checks_passed++;
                if (sel) begin tgt3 = 7; valid3 = 1'b1; end
                else     begin tgt1 = 7; valid1 = 1'b1; end
            end
            if (inject && (iter == 41 || iter == 141)) begin
                if (sel) valid3 = 1'b0; else valid1 = 1'b0;
            end

            if (iter > 0 && ps === 1'b1) ps_cnt++;

            if (d !== prev) begin
                checks_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL duty_step_extra: duty=%0d, want no change", d);
                end else begin
                    want = exp_q.pop_front();
                    if (d !== want) $display("FAIL duty_step: duty=%0d, want %0d", d, want);
                    else checks_passed++;
                end
                checks_total++;
                if (ps !== 1'b1) $display("FAIL duty_off_boundary: period_start=%b at change, want 1", ps);
                else checks_passed++;
                checks_total++;
                if (last_change < 0) begin
                    if (ps_cnt != hold) $display("FAIL first_step_latency: %0d boundaries, want %0d", ps_cnt, hold);
                    else checks_passed++;
                end else begin
                    if (iter - last_change != PLEN * hold)
                        $display("FAIL step_interval: %0d clk, want %0d", iter - last_change, PLEN * hold);
                    else checks_passed++;
                end
                last_change = iter;
                prev        = d;
            end

            if (dn === 1'b1) begin
                seen_done = 1;
                checks_total++;
                if (d !== t || bz !== 1'b0 || rdy !== 1'b1 || exp_q.size() != 0 ||
                    (nsteps > 0 && ps !== 1'b1) || (nsteps == 0 && iter != 0))
                    $display("FAIL done_state: duty=%0d busy=%b ready=%b ps=%b left=%0d iter=%0d, want duty=%0d busy=0 ready=1",
                             d, bz, rdy, ps, exp_q.size(), iter, t);
                else checks_passed++;
            end
        end
        if (!seen_done) begin
            checks_total++;
            $display("FAIL done_timeout: no done within %0d clk for target %0d", budget, t);
        end
        md[sel] = t;

        @(negedge clk);
        dn = sel ? done3 : done1;
        checks_total++;
        if (dn !== 1'b0) $display("FAIL done_width: done=%b one clock later, want 0", dn);
        else checks_passed++;
        $display("ramp: inst=h%0d req=%0d tgt=%0d steps=%0d", sel ? 3 : 1, req, t, nsteps);
    endtask

    // ---------------------------------------------------------------------
    task automatic test_ramp_up();
        run_ramp(0, 35, 1, 0);
    endtask

    task automatic test_ramp_down();
        run_ramp(0, 50, 1, 0);
        run_ramp(0, 0, 1, 0);
    endtask

    task automatic test_clamp();
        run_ramp(0, 95, 1, 0);
        run_ramp(0, 500, 1, 0);
        run_ramp(1, 95, 3, 0);
        run_ramp(1, 500, 3, 0);
    endtask

    task automatic test_equal_and_ignore();
        run_ramp(0, 101, 1, 0);
        run_ramp(0, 300, 1, 0);
        run_ramp(0, 35, 1, 1);
    endtask

    task automatic test_back_to_back();
        run_ramp(0, 25, 1, 0);
        run_ramp(0, 20, 1, 0);
    endtask

    task automatic test_reset_mid_ramp();
        int  k;
        bit  hit;
        bit  first_seen;
        bit  fin;
        tgt1 = 80; valid1 = 1'b1;
        hit  = 0;
        for (k = 0; k < 500 && !hit; k++) begin
            @(negedge clk);
            if (k == 0) valid1 = 1'b0;
            if (duty1 === 40) hit = 1;
        end
        checks_total++;
        if (!hit) $display("FAIL mid_ramp_reach: duty=%0d, want 40 within 500 clk", duty1);
        else checks_passed++;

        #2 rst_n = 1'b0;
        #1;
        checks_total++;
        if (duty1 !== 0 || busy1 !== 1'b0 || ready1 !== 1'b1 || done1 !== 1'b0 || ps1 !== 1'b0)
            $display("FAIL async_reset: duty=%0d busy=%b ready=%b done=%b ps=%b, want 0/0/1/0/0",
                     duty1, busy1, ready1, done1, ps1);
        else checks_passed++;

        @(negedge clk);
        rst_n = 1'b1;
        md[0] = '0;
        md[1] = '0;
        tgt1 = 30; valid1 = 1'b1;
        first_seen = 0;
        fin        = 0;
        for (k = 1; k <= 400 && !fin; k++) begin
            @(negedge clk);
            if (k == 1) valid1 = 1'b0;
            if (!first_seen && duty1 !== 0) begin
                first_seen = 1;
                checks_total++;
                if (k != PLEN || duty1 !== 10)
                    $display("FAIL post_reset_first_step: duty=%0d at clk %0d, want 10 at clk %0d", duty1, k, PLEN);
                else checks_passed++;
            end
            if (done1 === 1'b1) begin
                fin = 1;
                checks_total++;
                if (k != 3 * PLEN || duty1 !== 30)
                    $display("FAIL post_reset_done: duty=%0d at clk %0d, want 30 at clk %0d", duty1, k, 3 * PLEN);
                else checks_passed++;
            end
        end
        if (!fin) begin
            checks_total++;
            $display("FAIL post_reset_timeout: no done within 400 clk");
        end
        md[0] = 30;
        $display("reset_mid_ramp: aborted at duty 40, re-ramped to 30");
    endtask

    // ---------------------------------------------------------------------
    initial begin
        checks_total  = 0;
        checks_passed = 0;
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp();
        test_equal_and_ignore();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
